issue_scoreboard: RTL

// - Gates dispatch into the EX units (ALU/BRU) on register hazards. It tracks in-flight destination

---
 rtl/issue_scoreboard_pkg.sv | 26 ++
 rtl/issue_scoreboard_if.sv | 31 +++
 rtl/issue_scoreboard_reg_counter.sv | 41 ++++
 rtl/issue_scoreboard.sv | 107 ++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: register index, per-register count and issue descriptor.
package issue_scoreboard_pkg;

  localparam int unsigned NUM_REGS        = 32;
  localparam int unsigned SB_MAX_PER_REG  = 3;
  localparam int unsigned SB_MAX_INFLIGHT = 4;
  localparam int unsigned SB_CW           = $clog2(SB_MAX_PER_REG + 1);

  typedef logic [4:0]       reg_idx_t;
  typedef logic [SB_CW-1:0] sb_cnt_t;

  // Issue-side operand descriptor, kept packed for later axis packing.
  typedef struct packed {
    reg_idx_t rs1;
    logic     rs1_vld;
    reg_idx_t rs2;
    logic     rs2_vld;
    reg_idx_t rd;
    logic     rd_vld;
  } sb_iss_t;

  function automatic logic reg_live(reg_idx_t r, logic vld);
    return vld && (r != '0);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Dispatcher -> scoreboard -> EX handshake plus the committer->RF writeback observation.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic     iss_tvalid;
  logic     iss_tready;
  reg_idx_t iss_rs1;
  logic     iss_rs1_vld;
  reg_idx_t iss_rs2;
  logic     iss_rs2_vld;
  reg_idx_t iss_rd;
  logic     iss_rd_vld;
  logic     ex_tvalid;
  logic     ex_tready;
  logic     wb_tvalid;
  reg_idx_t wb_rd;
  logic     wb_rd_vld;

  modport master (
    output iss_tvalid, iss_rs1, iss_rs1_vld, iss_rs2, iss_rs2_vld, iss_rd, iss_rd_vld,
    output ex_tready, wb_tvalid, wb_rd, wb_rd_vld,
    input  iss_tready, ex_tvalid
  );

  modport slave (
    input  iss_tvalid, iss_rs1, iss_rs1_vld, iss_rs2, iss_rs2_vld, iss_rd, iss_rd_vld,
    input  ex_tready, wb_tvalid, wb_rd, wb_rd_vld,
    output iss_tready, ex_tvalid
  );

endinterface

// File: rtl/issue_scoreboard_reg_counter.sv
// sb_reg_counter: saturating up/down count of outstanding writes to one register.
module sb_reg_counter #(
  parameter int unsigned MaxCnt = 3,
  parameter int unsigned Cw     = $clog2(MaxCnt + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [Cw-1:0] cnt,
  output logic          err
);

  logic [Cw-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && dec) begin
      // Net zero; a retire with nothing outstanding is still an error.
      err = (cnt_q == '0);
    end else if (inc) begin
      if (cnt_q == Cw'(MaxCnt)) err = 1'b1;
      else                      cnt_d = cnt_q + Cw'(1);
    end else if (dec) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - Cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard issue gate between dispatcher and EX FIFO.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a hazard/full slot.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_PER_REG  = SB_MAX_PER_REG,
  parameter int unsigned MAX_INFLIGHT = SB_MAX_INFLIGHT,
  parameter int unsigned CW           = $clog2(MAX_PER_REG + 1),
  parameter int unsigned CI           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  issue_scoreboard_if.slave   bus,
  input  logic                flush,
  output logic [CI-1:0]       inflight,
  output logic                sb_err
);

  sb_iss_t       iss;
  logic [CW-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] reg_err;
  logic [CI-1:0] inflight_d, inflight_q;
  logic          sb_err_q;

  logic rd_eff, wb_ret, ret_live, hazard, full, ok, fire;
  logic rs1_byp, rs2_byp, rd_free, if_free;
  logic if_inc, if_dec, if_ovf;

  assign iss = '{rs1: bus.iss_rs1, rs1_vld: bus.iss_rs1_vld,
                 rs2: bus.iss_rs2, rs2_vld: bus.iss_rs2_vld,
                 rd:  bus.iss_rd,  rd_vld:  bus.iss_rd_vld};

  assign cnt[0]     = '0;
  assign reg_err[0] = 1'b0;

  assign rd_eff   = reg_live(iss.rd, iss.rd_vld);
  assign wb_ret   = bus.wb_tvalid && reg_live(bus.wb_rd, bus.wb_rd_vld);
  assign ret_live = wb_ret && (cnt[bus.wb_rd] != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign rs1_byp = wb_ret && (bus.wb_rd == iss.rs1) && (cnt[iss.rs1] == CW'(1));
  assign rs2_byp = wb_ret && (bus.wb_rd == iss.rs2) && (cnt[iss.rs2] == CW'(1));
  assign rd_free = wb_ret && (bus.wb_rd == iss.rd);
  assign if_free = ret_live;
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
  assign rd_free = 1'b0;
  assign if_free = 1'b0;
`endif

  // x0 always reads a zero count, so sources of 0 never hazard.
  assign hazard = (iss.rs1_vld && (cnt[iss.rs1] != '0) && !rs1_byp) ||
                  (iss.rs2_vld && (cnt[iss.rs2] != '0) && !rs2_byp);
  assign full   = rd_eff && (((cnt[iss.rd] == CW'(MAX_PER_REG)) && !rd_free) ||
                             ((inflight_q == CI'(MAX_INFLIGHT)) && !if_free));

  assign ok             = !hazard && !full && !flush && !rst;
  assign bus.ex_tvalid  = bus.iss_tvalid && ok;
  assign bus.iss_tready = bus.ex_tready && ok;
  assign fire           = bus.ex_tvalid && bus.ex_tready;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_reg_counter #(
      .MaxCnt (MAX_PER_REG),
      .Cw     (CW)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (fire && rd_eff && (iss.rd == reg_idx_t'(r))),
      .dec (wb_ret && (bus.wb_rd == reg_idx_t'(r))),
      .cnt (cnt[r]),
      .err (reg_err[r])
    );
  end

  // A retire against an empty register is an error, not a real completion.
  assign if_inc = fire && rd_eff;
  assign if_dec = ret_live;
  assign if_ovf = if_inc && !if_dec && (inflight_q == CI'(MAX_INFLIGHT));

  always_comb begin
    inflight_d = inflight_q;
    if (flush) begin
      inflight_d = '0;
    end else if (if_inc && !if_dec && !if_ovf) begin
      inflight_d = inflight_q + CI'(1);
    end else if (if_dec && !if_inc) begin
      inflight_d = inflight_q - CI'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_q | (|reg_err) | if_ovf;
    end
  end

  assign inflight = rst ? '0 : inflight_q;
  assign sb_err   = rst ? 1'b0 : sb_err_q;

endmodule
